// File: rtl/uart_tx_drain_pkg.sv
// Shared UART definitions: FSM state encodings and bit-period computation.
// Kept free of tx-specific logic so a receiver can import the same package.
package uart_tx_drain_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Integer clocks per bit, clamped so a bit always spans at least two cycles.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    int c;
    c = clk_freq / baud_rate;
    return (c < 2) ? 2 : c;
  endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// Read port of the upstream byte FIFO as seen by the serial drain.
// fifo_rd_en is a one-cycle strobe raised only while fifo_empty=0; the popped
// byte appears on fifo_data in the following cycle with no further handshake.
interface uart_tx_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_tx_drain_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// Drains bytes from an upstream FIFO and serialises them as 8N1 frames, LSB first.
// tx is registered from the next-state values so it changes only on clock edges.
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_drain_if.master   fifo,
  output logic              tx,
  output logic              busy,
  output state_t            state
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

  state_t     state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       armed_q;
  logic       rd_en;
  logic       tick;
  logic       baud_clear;
  logic       tx_d;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // armed_q holds off the first read until one rising edge has passed out of reset.
  always_comb begin
    state_d   = state;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    case (state)
      IDLE:  if (armed_q && !fifo.fifo_empty) state_d = FETCH;
      FETCH: begin
        shift_d   = fifo.fifo_data;
        bit_idx_d = 3'd0;
        state_d   = START;
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en           = (state == IDLE) && armed_q && !fifo.fifo_empty;
    fifo.fifo_rd_en = rd_en;
    busy            = (state != IDLE) || rd_en;
    baud_clear      = (state_d != state) || (state == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      tx        <= 1'b1;
      armed_q   <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx        <= tx_d;
      armed_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain at 4 clocks per bit, with a behavioural 8-deep FIFO
// upstream and a serial decoder feeding an expected-byte scoreboard.
module tb_uart_tx_drain;
  import uart_tx_drain_pkg::*;

  localparam int LOG_N = 4096;

  logic       clk;
  logic       rst_n;
  logic       fifo_rst_n;
  logic       tx;
  logic       busy;
  state_t     dut_state;
  logic       wr_en;
  logic [7:0] wr_data;

  uart_tx_drain_if fifo_if ();

  uart_tx_drain #(
    .CLK_FREQ (4),
    .BAUD_RATE(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fifo (fifo_if.master),
    .tx   (tx),
    .busy (busy),
    .state(dut_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // behavioural upstream FIFO, reset independently of the DUT
  logic [7:0] mem [8];
  logic [2:0] wp, rp;
  logic [3:0] fifo_words;
  logic       do_rd, do_wr;

  assign do_rd = fifo_if.fifo_rd_en && (fifo_words != 4'd0);
  assign do_wr = wr_en && ((fifo_words != 4'd8) || do_rd);
  assign fifo_if.fifo_empty = (fifo_words == 4'd0);

  always @(posedge clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wp <= 3'd0;
      rp <= 3'd0;
      fifo_words <= 4'd0;
      fifo_if.fifo_data <= 8'h00;
    end else begin
      if (do_wr) begin
        mem[wp] <= wr_data;
        wp <= wp + 3'd1;
      end
      if (do_rd) begin
        fifo_if.fifo_data <= mem[rp];
        rp <= rp + 3'd1;
      end
      fifo_words <= fifo_words + {3'b000, do_wr} - {3'b000, do_rd};
    end
  end

  // scoreboard state
  logic [7:0] exp_q[$];
  int         rd_q[$];
  int         start_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         busy_cnt = 0;
  int         rd_viol  = 0;
  logic       tx_log [LOG_N];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: logs tx, counts strobes and busy cycles, decodes frames
  bit         dec_act = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (cyc < LOG_N) tx_log[cyc] = tx;
    if (fifo_if.fifo_rd_en) begin
      rd_q.push_back(cyc);
      if (fifo_if.fifo_empty) rd_viol++;
    end
    if (busy) busy_cnt++;
    if (!rst_n) begin
      dec_act = 1'b0;
    end else if (!dec_act) begin
      if (tx == 1'b0) begin
        dec_act = 1'b1;
        dec_cnt = 0;
        start_q.push_back(cyc);
      end
    end else begin
      dec_cnt++;
      if ((dec_cnt % 4 == 2) && dec_cnt >= 6 && dec_cnt <= 34)
        dec_byte[(dec_cnt - 6) / 4] = tx;
      if (dec_cnt == 38) begin
        check("stop_bit", int'(tx), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", int'(dec_byte), -1);
        end else begin
          check("frame_byte", int'(dec_byte), int'(exp_q.pop_front()));
        end
        dec_act = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic push_byte(input logic [7:0] b, input bit expect_it);
    wr_en   = 1'b1;
    wr_data = b;
    if (expect_it) exp_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(n >= max_cyc), 0);
    repeat (3) @(negedge clk);
  endtask

  function automatic int log_at(input int idx);
    if (idx < 0 || idx >= LOG_N) return -1;
    return int'(tx_log[idx]);
  endfunction

  task automatic clear_stats();
    rd_q.delete();
    start_q.delete();
    busy_cnt = 0;
  endtask

  initial begin
    logic [9:0] pat;
    int         bad, low, s, r, found;
    logic [3:0] lvl;

    rst_n = 1'b0;
    fifo_rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    repeat (2) @(negedge clk);
    fifo_rst_n = 1'b1;

    // reset held with a non-empty FIFO: outputs stay quiet
    push_byte(8'hA5, 1'b1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_if.fifo_rd_en !== 1'b0) bad++;
    end
    check("reset_quiet_cycles", bad, 0);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_rd_en", int'(fifo_if.fifo_rd_en), 0);
    check("reset_state", int'(dut_state), int'(IDLE));

    // single byte 0xA5 released from reset
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    clear_stats();
    #1;
    check("rd_en_before_first_edge", int'(fifo_if.fifo_rd_en), 0);
    wait_done(200, "a5_timeout");
    check("a5_strobes", rd_q.size(), 1);
    check("a5_starts", start_q.size(), 1);
    check("a5_latency", (start_q.size() > 0 && rd_q.size() > 0) ? start_q[0] - rd_q[0] : -1, 2);
    check("a5_busy_cycles", busy_cnt, 42);
    pat = 10'b1101001010;
    s = (rd_q.size() > 0) ? rd_q[0] : 0;
    check("a5_idle_rd_cycle", log_at(s), 1);
    check("a5_idle_fetch_cycle", log_at(s + 1), 1);
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) lvl[j] = tx_log[(s + 2 + 4 * k + j) % LOG_N];
      check($sformatf("a5_level_%0d", k), int'(lvl), pat[k] ? 15 : 0);
    end

    // back-to-back 0x00 then 0xFF
    clear_stats();
    push_byte(8'h00, 1'b1);
    push_byte(8'hFF, 1'b1);
    wait_done(400, "b2b_timeout");
    check("b2b_strobes", rd_q.size(), 2);
    check("b2b_starts", start_q.size(), 2);
    s = (start_q.size() > 0) ? start_q[0] : 0;
    check("b2b_start_spacing", (start_q.size() > 1) ? start_q[1] - start_q[0] : -1, 42);
    check("b2b_stop_last", log_at(s + 39), 1);
    check("b2b_gap_idle", log_at(s + 40), 1);
    check("b2b_gap_fetch", log_at(s + 41), 1);

    // empty FIFO for 100 cycles
    clear_stats();
    low = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    check("empty_strobes", rd_q.size(), 0);
    check("empty_tx_low_cycles", low, 0);

    // reset during data bit 3 of 0x3C; the byte is lost
    clear_stats();
    push_byte(8'h3C, 1'b0);
    found = 0;
    for (int n = 0; n < 30 && found == 0; n++) begin
      @(negedge clk);
      #1;
      if (rd_q.size() > 0) found = 1;
    end
    check("midrst_strobe_seen", found, 1);
    repeat (19) @(negedge clk);
    #1;
    check("midrst_busy_before", int'(busy), 1);
    check("midrst_state_before", int'(dut_state), int'(DATA));
    rst_n = 1'b0;
    #1;
    check("midrst_tx_async", int'(tx), 1);
    check("midrst_busy_async", int'(busy), 0);
    check("midrst_state_async", int'(dut_state), int'(IDLE));
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("midrst_strobes", rd_q.size(), 1);
    check("midrst_starts", start_q.size(), 1);
    check("midrst_tx_idle", int'(tx), 1);

    // integration: 8 bytes through the FIFO
    clear_stats();
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b1);
    wait_done(8 * 42 + 100, "fifo8_timeout");
    check("fifo8_strobes", rd_q.size(), 8);
    check("fifo8_starts", start_q.size(), 8);
    check("fifo8_words", int'(fifo_words), 0);
    check("read_while_empty", rd_viol, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
